// File: rtl/kernel_cc_fifo_burst_writer.sv
// kernel_cc_fifo_burst_writer: drains the kernel_cc FIFO into global memory as AXI4 INCR write bursts
module kernel_cc_fifo_burst_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  fifo_empty_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [7:0]            m_wstrb,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp
);
  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, RESP, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  remain;
  logic [7:0]            beat;
  logic [12:0]           room, cap;
  logic [8:0]            blen;
  logic                  w_hs;
  // beats left before the next 4 KB page, then clipped by burst cap and remaining words
  assign room = (13'h1000 - {1'b0, addr[11:0]}) >> 3;
  assign cap  = room < 13'(MAX_BURST) ? room : 13'(MAX_BURST);
  assign blen = remain < CNT_WIDTH'(cap) ? 9'(remain) : 9'(cap);
  assign busy      = state != IDLE;
  assign done      = state == FIN;
  assign m_awvalid = state == ADDR;
  assign m_awaddr  = addr;
  assign m_awsize  = 3'b011;
  assign m_awburst = 2'b01;
  assign m_wvalid  = (state == DATA) & fifo_empty_n;
  assign m_wdata   = fifo_dout;
  assign m_wstrb   = 8'hFF;
  assign m_wlast   = (state == DATA) & (beat == m_awlen);
  assign m_bready  = state == RESP;
  assign w_hs      = m_wvalid & m_wready;
  assign fifo_read = w_hs;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CALC : IDLE;
      CALC:    state_nx = remain == '0 ? FIN : ADDR;
      ADDR:    state_nx = m_awready ? DATA : ADDR;
      DATA:    state_nx = (w_hs & m_wlast) ? RESP : DATA;
      RESP:    state_nx = m_bvalid ? CALC : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      remain  <= '0;
      beat    <= '0;
      m_awlen <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        addr   <= base_addr;
        remain <= num_words;
        err    <= 1'b0;
      end
      if (state == CALC && remain != '0) m_awlen <= 8'(blen - 9'd1);
      if (state == ADDR && m_awready) beat <= '0;
      if (state == DATA && w_hs) begin
        beat <= beat + 8'd1;
        if (m_wlast) begin
          addr   <= addr + ((ADDR_WIDTH'(m_awlen) + ADDR_WIDTH'(1)) << 3);
          remain <= remain - CNT_WIDTH'(m_awlen) - CNT_WIDTH'(1);
        end
      end
      if (state == RESP && m_bvalid && m_bresp != 2'b00) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kernel_cc_fifo_burst_writer.sv
// tb_kernel_cc_fifo_burst_writer: job table plus scoreboarded AXI/FIFO model for the burst writer
module tb_kernel_cc_fifo_burst_writer;
  logic        clk = 0, reset = 1, start = 0;
  logic [63:0] base_addr = '0;
  logic [31:0] num_words = '0;
  logic        busy, done, err, fifo_empty_n = 0, fifo_read;
  logic [63:0] fifo_dout = '0;
  logic        m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_wlast, m_bvalid = 0, m_bready;
  logic [63:0] m_awaddr, m_wdata;
  logic [7:0]  m_awlen, m_wstrb;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp = 0;

  kernel_cc_fifo_burst_writer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .err(err), .fifo_empty_n(fifo_empty_n), .fifo_dout(fifo_dout),
    .fifo_read(fifo_read), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] base; logic [31:0] num; int err_burst; bit rnd; } vec_t;
  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  vec_t        tbl[8];
  aw_t         exp_aw[$];
  logic [63:0] exp_w[$], fifo_q[$], pend[$];
  int          vecs = 0, bad = 0;
  int          b_idx, err_burst, wbeat, cur_len, done_cnt, done_cyc, first_aw, k, w_total;
  bit          rnd, aw_open, exp_err, p_aws, p_ws, p_wlast;
  logic [63:0] p_awaddr, p_wdata;
  logic [7:0]  p_awlen;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [63:0] w;
    if (rnd) begin
      m_awready = 1'($urandom_range(0, 1));
      m_wready  = 1'($urandom_range(0, 1));
      m_bvalid  = 1'($urandom_range(0, 2) != 0);
      if (pend.size() > 0 && fifo_q.size() < 128 && $urandom_range(0, 1) == 1) begin
        w = pend.pop_front();
        fifo_q.push_back(w);
        exp_w.push_back(w);
      end
    end else begin
      m_awready = 1; m_wready = 1; m_bvalid = 1;
      while (pend.size() > 0 && fifo_q.size() < 128) begin
        w = pend.pop_front();
        fifo_q.push_back(w);
        exp_w.push_back(w);
      end
    end
    m_bresp      = (b_idx == err_burst) ? 2'd2 : 2'd0;
    fifo_empty_n = fifo_q.size() > 0;
    fifo_dout    = fifo_empty_n ? fifo_q[0] : '0;
  endtask

  task automatic cycle();
    aw_t e;
    bit  rd, b_hs;
    @(negedge clk);
    k++;
    if (p_aws) begin
      check("aw_hold_valid", m_awvalid, 1);
      check("aw_hold_addr", m_awaddr, p_awaddr);
      check("aw_hold_len", m_awlen, p_awlen);
    end
    if (p_ws) begin
      check("w_hold_valid", m_wvalid, 1);
      check("w_hold_data", m_wdata, p_wdata);
      check("w_hold_last", m_wlast, p_wlast);
    end
    if (m_wvalid) check("w_before_aw", aw_open, 1);
    if (fifo_read) check("read_nonempty", fifo_q.size() > 0, 1);
    if (m_awvalid && first_aw < 0) first_aw = k;
    if (m_awvalid && m_awready) begin
      if (exp_aw.size() == 0) check("aw_extra", 1, 0);
      else begin
        e = exp_aw.pop_front();
        check("awaddr", m_awaddr, e.addr);
        check("awlen", m_awlen, e.len);
        cur_len = e.len; wbeat = 0; aw_open = 1;
      end
    end
    if (m_wvalid && m_wready) begin
      if (exp_w.size() == 0) check("w_extra", 1, 0);
      else check("wdata", m_wdata, exp_w.pop_front());
      check("wlast", m_wlast, wbeat == cur_len);
      wbeat++; w_total++;
      if (m_wlast) aw_open = 0;
    end
    if (done) begin
      done_cnt++; done_cyc = k;
      check("err_at_done", err, exp_err);
    end
    rd    = fifo_read;
    b_hs  = m_bvalid & m_bready;
    p_aws = m_awvalid & !m_awready; p_awaddr = m_awaddr; p_awlen = m_awlen;
    p_ws  = m_wvalid & !m_wready;   p_wdata = m_wdata;   p_wlast = m_wlast;
    @(posedge clk); #1;
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (b_hs) b_idx++;
    drive_inputs();
  endtask

  task automatic prepare(input logic [63:0] base, input logic [31:0] num, input int eb, input bit r);
    logic [63:0] a;
    longint      rem;
    int          room, b, idx;
    exp_aw.delete(); exp_w.delete(); fifo_q.delete(); pend.delete();
    a = base; rem = num; idx = 0; exp_err = 0;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      b = (rem < 16) ? int'(rem) : 16;
      if (b > room) b = room;
      exp_aw.push_back('{a, 8'(b - 1)});
      if (idx == eb) exp_err = 1;
      a += 64'(b * 8); rem -= b; idx++;
    end
    for (int i = 0; i < int'(num); i++) pend.push_back({$urandom(), $urandom()});
    b_idx = 0; err_burst = eb; rnd = r; done_cnt = 0; done_cyc = -1; first_aw = -1;
    aw_open = 0; p_aws = 0; p_ws = 0; k = 0; w_total = 0;
    base_addr = base; num_words = num; start = 1;
    drive_inputs();
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
  endtask

  task automatic run_job(input vec_t v);
    prepare(v.base, v.num, v.err_burst, v.rnd);
    while (done_cnt == 0 && k < 20000) cycle();
    if (done_cnt == 0) check("timeout", 0, 1);
    cycle();
    check("done_once", done_cnt, 1);
    check("idle_after", busy, 0);
    check("aw_left", exp_aw.size(), 0);
    check("w_left", exp_w.size() + pend.size() + fifo_q.size(), 0);
    check("pops", w_total, v.num);
    if (v.num == 0) check("zero_done_cyc", done_cyc, 2);
    else check("first_aw_cyc", first_aw, 2);
  endtask

  initial begin
    tbl[0] = '{64'h1000, 32'd40, -1, 0};
    tbl[1] = '{64'h0FE0, 32'd10, -1, 0};
    tbl[2] = '{64'h0, 32'd0, -1, 0};
    tbl[3] = '{64'h2000, 32'd500, -1, 1};
    tbl[4] = '{64'h3000, 32'd40, 1, 0};
    tbl[5] = '{64'h4008, 32'd3, -1, 1};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFF0, 32'd4, -1, 1};
    tbl[7] = '{64'h5FF8, 32'd300, 6, 1};
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_awaddr", m_awaddr, 0);
    check("rst_awlen", m_awlen, 0);
    check("rst_err", err, 0);
    check("awsize", m_awsize, 3);
    check("awburst", m_awburst, 1);
    check("wstrb", m_wstrb, 8'hFF);
    reset = 0;
    for (int i = 0; i < 8; i++) run_job(tbl[i]);
    prepare(64'h6000, 32'd40, -1, 0);
    while (w_total < 5 && k < 200) cycle();
    check("mid_beats", w_total, 5);
    reset = 1;
    @(posedge clk); #1;
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_err", err, 0);
    check("mr_valids", {m_awvalid, m_wvalid, m_bready, fifo_read, m_wlast}, 0);
    check("mr_awaddr", m_awaddr, 0);
    check("mr_awlen", m_awlen, 0);
    reset = 0;
    run_job('{64'h7000, 32'd20, -1, 1});
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
